param_univ_shift_reg: RTL
=========================

Name: param_univ_shift_reg

Overview:
Next-generation parametrised shift register, successor to the single-mode LEFT/RIGHT shift register.
- Supports width-generic shift and rotate operations, selectable per cycle, with a multi-bit shift amount.
- Adds a burst serializer: one start pulse loads a word and shifts it out over WIDTH cycles, with busy/done status.
- Serves as the datapath shifter and serial-out stage for the lab UART/SPI exercises.

Parameters:
- WIDTH, 8, register width in bits; must be ≥2.
- SSET_VALUE, 4, value loaded by sset, truncated to WIDTH.
- BURST_DIR, "LEFT", burst shift direction. "LEFT" shifts MSB first; "RIGHT" shifts LSB first.
- AMT_W, $clog2(WIDTH), width of the amount port (derived; do not override).

Ports:
- clock  in  1  rising-edge clock.
- sclr  in  1  synchronous active-high reset/clear. Highest priority; not gated by enable.
- enable  in  1  clock enable for every operation except sclr.
- sset  in  1  synchronous set to SSET_VALUE.
- load  in  1  parallel load of data.
- data  in  WIDTH  parallel load / burst word.
- mode  in  3  0 hold, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5 ASR, 6/7 hold.
- amount  in  AMT_W  shift distance for manual modes; 0 means hold.
- shiftin  in  1  fill bit for SHL/SHR and during burst.
- start  in  1  burst request, sampled in IDLE only.
- q  out  WIDTH  register contents.
- shiftout  out  1  last bit shifted out (registered).
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset: on an edge with sclr=1, all outputs clear: q=0, shiftout=0, busy=0, done=0, state=IDLE, count=0.
- sclr aborts a burst. No done pulse is generated for an aborted burst.
- Priority at each edge: sclr > (enable=0: hold all state) > sset > load > burst logic > manual mode > hold.
- done defaults low every edge; it is high for exactly one cycle after burst completion.
- sset:
  - q=SSET_VALUE, shiftout unchanged.
  - A burst in progress is aborted: state=IDLE, busy=0, no done.
- load (IDLE only): q=data, shiftout unchanged. load is ignored while busy.
- Manual modes (IDLE, no start), with k = amount:
  - SHL: q = {q[WIDTH-1-k:0], k copies of shiftin}; shiftout = old q[WIDTH-k].
  - SHR: q = {k copies of shiftin, q[WIDTH-1:k]}; shiftout = old q[k-1].
  - ROL/ROR: circular shift by k; shiftout is the same index as SHL/SHR respectively.
  - ASR: fill bits are old q[WIDTH-1]; shiftout = old q[k-1].
  - k=0 or mode 0/6/7: q and shiftout hold.
- Burst FSM (states IDLE, SHIFT):
  - IDLE, start=1 with no sset/load: at edge N, q=data, count=WIDTH, busy=1, state=SHIFT. start takes precedence over mode.
  - SHIFT, each enabled edge: shift by 1 in BURST_DIR, fill with shiftin, shiftout = bit shifted out, count decrements.
  - At the edge where count reaches 0 (edge N+WIDTH when enable stays high): state=IDLE, busy=0, done=1.
  - enable=0 freezes count, q and state; the burst is lengthened by the number of disabled cycles.
  - start, load and mode are ignored while busy.
  - start in the same cycle as done is high (state already IDLE): accepted. Back-to-back bursts therefore have no gap.
- Arithmetic: amount is unsigned. Values ≥WIDTH cannot occur when WIDTH is a power of two. Otherwise an amount ≥WIDTH is treated as hold.

Decomposition:
- Shared package shift_pkg: mode localparams (MODE_HOLD..MODE_ASR), state encoding (ST_IDLE, ST_SHIFT).
- One combinational sub-module, shift_core.
  - Inputs: q, mode, amount, shiftin. Outputs: next_q, next_shiftout.
  - Implemented as a barrel shifter.
  - Reused by the burst path with mode forced to SHL/SHR and amount=1.
- The top level holds the registers, the priority logic and the FSM.

Test Plan:
- sclr=1 for 20 cycles with random enable/sset/load/start/data -> q=8'h00, shiftout=0, busy=0, done=0 every cycle.
- enable=1, sset=1, load=1, data=8'hA5 -> q=8'h04. Then sset=0, load=1 -> q=8'hA5. Then enable=0, load=1, data=8'h3C -> q stays 8'hA5.
- Load 8'hB4, then mode=ROL, amount=3 -> q=8'hA5, shiftout=1. Load 8'h90, then mode=ASR, amount=2 -> q=8'hE4, shiftout=0.
- start=1, data=8'hC5, shiftin=0, enable=1 -> busy=1 from edge N. shiftout after edges N+1..N+8 = 1,1,0,0,0,1,0,1. done=1 only after edge N+8. Final q=8'h00, busy=0.
- Repeat the burst with enable=0 for 2 cycles after edge N+4 -> done after edge N+10. Bit sequence unchanged.
- Burst from 8'hC5; sclr=1 at edge N+3 -> q=0, busy=0, no done pulse. A new start at edge N+5 is accepted.

Source files
------------

// File: rtl/param_univ_shift_reg_pkg.sv
// shift_pkg: mode codes and burst FSM states shared by the shifter and its datapath core.
package shift_pkg;
  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_SHL  = 3'd1;
  localparam logic [2:0] MODE_SHR  = 3'd2;
  localparam logic [2:0] MODE_ROL  = 3'd3;
  localparam logic [2:0] MODE_ROR  = 3'd4;
  localparam logic [2:0] MODE_ASR  = 3'd5;
  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
endpackage

// File: rtl/shift_core.sv
// shift_core: combinational barrel shifter for shift/rotate modes with a multi-bit amount.
module shift_core
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic             shiftin,
  input  logic             shiftout,
  output logic [WIDTH-1:0] next_q,
  output logic             next_shiftout
);
  logic [WIDTH-1:0] fill, sign, shl, shr, rol, ror, asr;
  logic hi_bit, lo_bit, valid;
  always_comb begin
    fill = {WIDTH{shiftin}};
    sign = {WIDTH{q[WIDTH-1]}};
    // Shifting the concatenation pulls the fill or wrap bits in from the partner half.
    shl = WIDTH'(({q, fill} << amount) >> WIDTH);
    shr = WIDTH'({fill, q} >> amount);
    rol = WIDTH'(({q, q} << amount) >> WIDTH);
    ror = WIDTH'({q, q} >> amount);
    asr = WIDTH'({sign, q} >> amount);
    hi_bit = 1'(q >> (WIDTH - int'(amount)));
    lo_bit = 1'(q >> (int'(amount) - 1));
    valid = amount != '0 && int'(amount) < WIDTH;
    next_q = !valid ? q :
             mode == MODE_SHL ? shl :
             mode == MODE_SHR ? shr :
             mode == MODE_ROL ? rol :
             mode == MODE_ROR ? ror :
             mode == MODE_ASR ? asr : q;
    next_shiftout = !valid ? shiftout :
                    (mode == MODE_SHL || mode == MODE_ROL) ? hi_bit :
                    (mode == MODE_SHR || mode == MODE_ROR || mode == MODE_ASR) ? lo_bit : shiftout;
  end
endmodule

// File: rtl/param_univ_shift_reg.sv
// param_univ_shift_reg: universal shift/rotate register with a WIDTH-cycle burst serializer.
module param_univ_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SSET_VALUE = 4,
  parameter     BURST_DIR  = "LEFT",
  parameter int AMT_W      = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             sclr,
  input  logic             enable,
  input  logic             sset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic             shiftin,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             shiftout,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] BURST_MODE = BURST_DIR == "LEFT" ? MODE_SHL : MODE_SHR;
  state_t state, state_n;
  logic [CW-1:0] count, count_n;
  logic [WIDTH-1:0] q_n, core_q;
  logic so_n, core_so, done_n;
  assign busy = state == ST_SHIFT;
  shift_core #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_core (
    .q(q),
    .mode(busy ? BURST_MODE : mode),
    .amount(busy ? AMT_W'(1) : amount),
    .shiftin(shiftin),
    .shiftout(shiftout),
    .next_q(core_q),
    .next_shiftout(core_so)
  );
  always_comb begin
    state_n = state;
    count_n = count;
    q_n = q;
    so_n = shiftout;
    done_n = 1'b0;
    if (enable) begin
      if (sset) begin
        q_n = WIDTH'(SSET_VALUE);
        state_n = ST_IDLE;
        count_n = '0;
      end else if (!busy && load) begin
        q_n = data;
      end else if (!busy && start) begin
        q_n = data;
        count_n = CW'(WIDTH);
        state_n = ST_SHIFT;
      end else begin
        q_n = core_q;
        so_n = core_so;
        if (busy) begin
          count_n = count - CW'(1);
          state_n = count == CW'(1) ? ST_IDLE : ST_SHIFT;
          done_n = count == CW'(1);
        end
      end
    end
  end
  always_ff @(posedge clock) begin
    if (sclr) begin
      state <= ST_IDLE;
      count <= '0;
      q <= '0;
      shiftout <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      q <= q_n;
      shiftout <= so_n;
      done <= done_n;
    end
  end
endmodule
